// File: rtl/page_mapper.sv
// page_mapper: banked page windows with a register file, a page-context stack
// that is saved/restored automatically on interrupt entry/exit, and four
// 24-bit interrupt vectors.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   AD, DI, DO        register address, write data, registered read data
//   rw, cs            access direction (1 = read) and strobe
//                     (one access per cycle)
//   int_enter/int_exit  one-cycle interrupt entry / return pulses
//   vec_sel, vec_addr   vector select and registered selected vector
//   page              NWIN windows of PW bits, window w at [w*PW +: PW]
//   bram_disable      built-in RAM disable (CTRL.RDS)
//   rom_wp            ROM page write lock (CTRL.LCK)
//   level             current stack occupancy
//
// Access semantics: a strobe (cs) qualifies exactly one access in the cycle it
// is high; no back-pressure exists. A read returns data on DO after the edge.
// A write takes effect at the same edge.
module page_mapper #(
    parameter int NWIN  = 2,
    parameter int PW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           AD,
    input  logic [7:0]           DI,
    output logic [7:0]           DO,
    input  logic                 rw,
    input  logic                 cs,
    input  logic                 int_enter,
    input  logic                 int_exit,
    input  logic [1:0]           vec_sel,
    output logic [23:0]          vec_addr,
    output logic [NWIN*PW-1:0]   page,
    output logic                 bram_disable,
    output logic                 rom_wp,
    output logic [3:0]           level
);

    logic [PW-1:0]      win_q [NWIN];
    logic [PW-1:0]      win_d [NWIN];
    logic               lck_q, lck_d;
    logic               rds_q, rds_d;
    logic               auto_q, auto_d;
    logic [PW-1:0]      irqpg_q, irqpg_d;
    logic [23:0]        vec_q [4];
    logic [23:0]        vec_d [4];
    logic [3:0]         level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [7:0]         do_q, do_d;
    logic [23:0]        vec_addr_q, vec_addr_d;

    // Stack storage is indexed directly by the 4-bit level; only entries
    // below DEPTH are ever written. It is not reset: clearing level is what
    // discards its contents.
    logic [NWIN*PW-1:0] stack_q [16];

    logic [NWIN*PW-1:0] cur_pages;
    logic [NWIN*PW-1:0] pop_word;
    logic [7:0]         rd_data;
    logic               wr, rd;
    logic               enter_ev, exit_ev, at_full, at_empty;
    logic               push, pop, ovf_set, unf_set;

    always_comb begin
        cur_pages = '0;
        for (int w = 0; w < NWIN; w++) begin
            cur_pages[w*PW +: PW] = win_q[w];
        end
    end

    assign wr = cs & ~rw;
    assign rd = cs & rw;

    // Simultaneous entry and exit cancel each other; with AUTO clear both
    // pulses are ignored completely.
    assign enter_ev = auto_q & int_enter & ~int_exit;
    assign exit_ev  = auto_q & int_exit & ~int_enter;
    assign at_full  = (level_q == 4'(DEPTH));
    assign at_empty = (level_q == 4'd0);
    assign push     = enter_ev & ~at_full;
    assign ovf_set  = enter_ev & at_full;
    assign pop      = exit_ev & ~at_empty;
    assign unf_set  = exit_ev & at_empty;
    assign pop_word = stack_q[level_q - 4'd1];

    // Read mux, built from pre-edge state only.
    always_comb begin
        rd_data = '0;
        for (int w = 0; w < NWIN; w++) begin
            if (AD == 5'(w)) begin
                rd_data[PW-1:0] = win_q[w];
            end
        end
        if (AD == 5'h04) rd_data = {5'b0, auto_q, rds_q, lck_q};
        if (AD == 5'h05) rd_data = {unf_q, ovf_q, 2'b0, level_q};
        if (AD == 5'h06) rd_data[PW-1:0] = irqpg_q;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 3; b++) begin
                if (AD == 5'(16 + 3*k + b)) begin
                    rd_data = vec_q[k][23-8*b -: 8];
                end
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NWIN; w++) win_d[w] = win_q[w];
        for (int k = 0; k < 4; k++) vec_d[k] = vec_q[k];
        lck_d      = lck_q;
        rds_d      = rds_q;
        auto_d     = auto_q;
        irqpg_d    = irqpg_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        do_d       = rd ? rd_data : do_q;
        vec_addr_d = vec_q[vec_sel];

        if (wr) begin
            // A stack operation owns all windows this edge.
            for (int w = 0; w < NWIN; w++) begin
                if (AD == 5'(w) && !(push || pop)) win_d[w] = DI[PW-1:0];
            end
            if (AD == 5'h04) begin
                lck_d  = DI[0];
                rds_d  = DI[1];
                auto_d = DI[2];
            end
            if (AD == 5'h05) begin
                if (DI[7]) unf_d = 1'b0;
                if (DI[6]) ovf_d = 1'b0;
            end
            if (AD == 5'h06) irqpg_d = DI[PW-1:0];
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 3; b++) begin
                    if (AD == 5'(16 + 3*k + b)) vec_d[k][23-8*b -: 8] = DI;
                end
            end
        end

        if (push) begin
            win_d[0] = irqpg_q;
            level_d  = level_q + 4'd1;
        end
        if (pop) begin
            for (int w = 0; w < NWIN; w++) win_d[w] = pop_word[w*PW +: PW];
            level_d = level_q - 4'd1;
        end

        // Setting after clearing makes a same-edge event win over a clear.
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NWIN; w++) win_q[w] <= '0;
            for (int k = 0; k < 4; k++) vec_q[k] <= '0;
            lck_q      <= 1'b0;
            rds_q      <= 1'b1;
            auto_q     <= 1'b0;
            irqpg_q    <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            do_q       <= '0;
            vec_addr_q <= '0;
        end else begin
            for (int w = 0; w < NWIN; w++) win_q[w] <= win_d[w];
            for (int k = 0; k < 4; k++) vec_q[k] <= vec_d[k];
            lck_q      <= lck_d;
            rds_q      <= rds_d;
            auto_q     <= auto_d;
            irqpg_q    <= irqpg_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            do_q       <= do_d;
            vec_addr_q <= vec_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack_q[level_q] <= cur_pages;
    end

    assign DO           = do_q;
    assign vec_addr     = vec_addr_q;
    assign page         = cur_pages;
    assign bram_disable = rds_q;
    assign rom_wp       = lck_q;
    assign level        = level_q;

endmodule

// File: tb/tb_page_mapper.sv
// Bench for page_mapper (default parameters): directed sequences with literal
// expectations followed by randomized traffic and occasional asynchronous
// resets, all compared every cycle against a behavioural model.
module tb_page_mapper;

    localparam int NWIN  = 2;
    localparam int PW    = 5;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [4:0]          AD = '0;
    logic [7:0]          DI = '0;
    logic [7:0]          DO;
    logic                rw = 1'b0;
    logic                cs = 1'b0;
    logic                int_enter = 1'b0;
    logic                int_exit = 1'b0;
    logic [1:0]          vec_sel = '0;
    logic [23:0]         vec_addr;
    logic [NWIN*PW-1:0]  page;
    logic                bram_disable;
    logic                rom_wp;
    logic [3:0]          level;

    int checks = 0;
    int errors = 0;

    page_mapper #(.NWIN(NWIN), .PW(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .int_enter(int_enter), .int_exit(int_exit), .vec_sel(vec_sel),
        .vec_addr(vec_addr), .page(page), .bram_disable(bram_disable),
        .rom_wp(rom_wp), .level(level)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model: windows, control bits, vectors, flags and a queue
    // holding the saved window sets (one int per set, window w in byte w)
    int m_win [4];
    int m_vec [4];
    int m_lck, m_rds, m_auto, m_irq, m_ovf, m_unf, m_do, m_va;
    int stk [$];

    task automatic model_reset();
        for (int w = 0; w < 4; w++) m_win[w] = 0;
        for (int k = 0; k < 4; k++) m_vec[k] = 0;
        m_lck = 0; m_rds = 1; m_auto = 0; m_irq = 0;
        m_ovf = 0; m_unf = 0; m_do = 0; m_va = 0;
        stk.delete();
    endtask

    function automatic int model_read(input int ad);
        int k, b;
        if (ad < NWIN) return m_win[ad];
        if (ad == 4) return m_auto * 4 + m_rds * 2 + m_lck;
        if (ad == 5) return m_unf * 128 + m_ovf * 64 + stk.size();
        if (ad == 6) return m_irq;
        if (ad >= 16 && ad <= 27) begin
            k = (ad - 16) / 3;
            b = (ad - 16) % 3;
            return (m_vec[k] >> (8 * (2 - b))) & 255;
        end
        return 0;
    endfunction

    task automatic model_step(input int c, input int r, input int ad, input int di,
                              input int en, input int ex, input int vs);
        int old_win [4];
        int old_irq, mask, nd, nva, ent_ev, ext_ev, push, pop, e, k, b;
        old_win = m_win;
        old_irq = m_irq;
        mask    = (1 << PW) - 1;
        nd      = (c != 0 && r != 0) ? model_read(ad) : m_do;
        nva     = m_vec[vs];
        ent_ev  = (m_auto != 0 && en != 0 && ex == 0) ? 1 : 0;
        ext_ev  = (m_auto != 0 && ex != 0 && en == 0) ? 1 : 0;
        push    = (ent_ev != 0 && stk.size() < DEPTH) ? 1 : 0;
        pop     = (ext_ev != 0 && stk.size() > 0) ? 1 : 0;
        if (c != 0 && r == 0) begin
            if (ad < NWIN && push == 0 && pop == 0) m_win[ad] = di & mask;
            if (ad == 4) begin
                m_lck = di & 1; m_rds = (di >> 1) & 1; m_auto = (di >> 2) & 1;
            end
            if (ad == 5) begin
                if (di & 128) m_unf = 0;
                if (di & 64)  m_ovf = 0;
            end
            if (ad == 6) m_irq = di & mask;
            if (ad >= 16 && ad <= 27) begin
                k = (ad - 16) / 3;
                b = (ad - 16) % 3;
                m_vec[k] = (m_vec[k] & ~(255 << (8 * (2 - b)))) | (di << (8 * (2 - b)));
            end
        end
        if (push != 0) begin
            e = 0;
            for (int w = 0; w < NWIN; w++) e = e | (old_win[w] << (8 * w));
            stk.push_back(e);
            m_win[0] = old_irq;
        end
        if (pop != 0) begin
            e = stk.pop_back();
            for (int w = 0; w < NWIN; w++) m_win[w] = (e >> (8 * w)) & 255;
        end
        if (ent_ev != 0 && push == 0) m_ovf = 1;
        if (ext_ev != 0 && pop == 0)  m_unf = 1;
        m_do = nd;
        m_va = nva;
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_page;
        exp_page = 0;
        for (int w = 0; w < NWIN; w++) exp_page = exp_page | (32'(m_win[w]) << (w * PW));
        chk("DO",           32'(DO),           32'(m_do));
        chk("vec_addr",     32'(vec_addr),     32'(m_va));
        chk("page",         32'(page),         exp_page);
        chk("level",        32'(level),        32'(stk.size()));
        chk("bram_disable", 32'(bram_disable), 32'(m_rds));
        chk("rom_wp",       32'(rom_wp),       32'(m_lck));
    endtask

    // driver: entered just after a falling edge, leaves at the next one
    task automatic cyc(input int c, input int r, input int ad, input int di,
                       input int en, input int ex, input int vs);
        cs = c[0]; rw = r[0]; AD = ad[4:0]; DI = di[7:0];
        int_enter = en[0]; int_exit = ex[0]; vec_sel = vs[1:0];
        @(posedge clk);
        model_step(c, r, ad, di, en, ex, vs);
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic wr_reg(input int ad, input int di);
        cyc(1, 0, ad, di, 0, 0, 0);
    endtask

    task automatic rd_reg(input int ad);
        cyc(1, 1, ad, 0, 0, 0, 0);
    endtask

    task automatic idle(input int en, input int ex, input int vs);
        cyc(0, 0, 0, 0, en, ex, vs);
    endtask

    task automatic async_rst();
        cs = 0; int_enter = 0; int_exit = 0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c, r, ad, di, en, ex, vs;
        int addr_tab [12] = '{0, 1, 2, 3, 4, 5, 6, 16, 20, 22, 27, 31};
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // reset state
        rd_reg(4'h4);  chk("ctrl_after_reset", 32'(DO), 32'h02);
        rd_reg(5);     chk("stat_after_reset", 32'(DO), 32'h00);
        chk("bram_disable_reset", 32'(bram_disable), 32'd1);
        chk("page_reset", 32'(page), 32'd0);

        // window writes, truncation, unmapped window
        wr_reg(0, 8'hFF);
        wr_reg(1, 8'h03);
        chk("page_after_writes", 32'(page), 32'd127);
        rd_reg(0);     chk("win0_read", 32'(DO), 32'h1F);
        rd_reg(2);     chk("win2_unmapped", 32'(DO), 32'h00);

        // one enter/exit round trip
        wr_reg(4, 8'h04);
        wr_reg(6, 7);
        wr_reg(0, 3);
        idle(1, 0, 0);
        chk("enter_win0", 32'(page) & 32'h1F, 32'd7);
        chk("enter_level", 32'(level), 32'd1);
        idle(0, 1, 0);
        chk("exit_win0", 32'(page) & 32'h1F, 32'd3);
        chk("exit_level", 32'(level), 32'd0);

        // overflow
        repeat (5) idle(1, 0, 0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_win0", 32'(page) & 32'h1F, 32'd7);
        rd_reg(5);     chk("stat_ovf", 32'(DO), 32'h44);
        wr_reg(5, 8'h40);
        rd_reg(5);     chk("stat_ovf_cleared", 32'(DO), 32'h04);

        // underflow and cancelling pulses
        repeat (4) idle(0, 1, 0);
        chk("unwound_win0", 32'(page) & 32'h1F, 32'd3);
        idle(0, 1, 0);
        rd_reg(5);     chk("stat_unf", 32'(DO), 32'h80);
        idle(1, 0, 0);
        idle(1, 1, 0);
        chk("enter_exit_same_cycle", 32'(level), 32'd1);

        // vector write and selection
        wr_reg(16'h16, 8'h12);
        wr_reg(16'h17, 8'h34);
        cyc(1, 0, 16'h18, 8'h56, 0, 0, 2);
        idle(0, 0, 2);
        chk("vec_addr_nmi", 32'(vec_addr), 32'h123456);

        // push beats a same-edge window write
        cyc(1, 0, 0, 8'h05, 1, 0, 0);
        chk("push_beats_write", 32'(page) & 32'h1F, 32'd7);
        chk("push_beats_write_lvl", 32'(level), 32'd2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_rst();
            c  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r  = $urandom_range(0, 1);
            ad = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31)
                                             : addr_tab[$urandom_range(0, 11)];
            di = $urandom_range(0, 255);
            if (ad == 4 && $urandom_range(0, 4) != 0) di = di | 4;
            en = ($urandom_range(0, 4) == 0) ? 1 : 0;
            ex = ($urandom_range(0, 4) == 0) ? 1 : 0;
            vs = $urandom_range(0, 3);
            if (i % 1000 == 0) begin
                c = 1; r = 0; ad = 4; di = 4;
            end
            cyc(c, r, ad, di, en, ex, vs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
